fp_normalizer: RTL and testbench
================================

FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 Parameter MW, 16, mantissa width in bits; legal values 8, 16, 32.
REQ-002 Parameter EW, 8, biased exponent width in bits.
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 iValid  input  1  upstream operand valid.
REQ-006 oReady  output  1  block accepts operand this cycle.
REQ-007 iSign  input  1  operand sign.
REQ-008 iExp  input  EW  operand biased exponent, unsigned.
REQ-009 iMant  input  MW  unnormalized operand mantissa, unsigned.
REQ-010 oValid  output  1  result valid.
REQ-011 iReady  input  1  downstream accepts result.
REQ-012 oSign, oExp, oMant  output  1/EW/MW  normalized result.
REQ-013 oZero  output  1  result is exact zero.
REQ-014 oDenorm  output  1  normalization clipped by exponent floor.

Function
REQ-015 Transfer in when iValid=1 and oReady=1; transfer out when oValid=1 and iReady=1.
REQ-016 Two-stage pipeline: S1 registers operand plus leading-zero count LZ, S2 registers shifted result; latency exactly 2 cycles with iReady held at 1.
REQ-017 LZ = number of zeros above the most-significant 1 of iMant, range 0..MW-1; LZ is don't-care when iMant=0.
REQ-018 The leading-zero count is built from 8-bit priority-encoder slices combined MSB-slice-first; no behavioural loop over bits.
REQ-019 If iMant=0: oMant=0, oExp=0, oZero=1, oDenorm=0, oSign=iSign.
REQ-020 Else if LZ <= iExp: oMant = iMant << LZ, oExp = iExp - LZ, oZero=0, oDenorm=0; oMant[MW-1] is then 1.
REQ-021 Else (LZ > iExp): oMant = iMant << iExp, oExp=0, oDenorm=1, oZero=0.
REQ-022 Shift fills with zeros; no bits are lost, since the shift amount never exceeds LZ.
REQ-023 oSign always equals the registered iSign of the same operand.
REQ-024 S2 loads when S2 is empty or iReady=1; S1 advances into S2 under the same condition.
REQ-025 S1 loads when S1 is empty or S1 is advancing this cycle.
REQ-026 oReady = (S1 empty) OR (S2 empty) OR iReady; combinational path from iReady is permitted.
REQ-027 oValid = S2 occupied; oValid, once high, stays high with all outputs stable until accepted.
REQ-028 Simultaneous input accept and output accept with both stages full: throughput 1/cycle, no bubble, no loss.
REQ-029 Results leave in acceptance order; no reordering, duplication or drop.

Reset
REQ-030 iRst_n=0 asynchronously clears both stage valid flags; oValid=0 immediately.
REQ-031 Output reset values: oSign=0, oExp=0, oMant=0, oZero=0, oDenorm=0, oValid=0.
REQ-032 Mid-operation reset discards all in-flight operands; the first result after release comes from the first operand accepted after release.
REQ-033 oReady=1 during and after reset, provided iRst_n=1 for the accepting edge.

Verification
REQ-034 MW=16, EW=8, iMant=0x0010, iExp=20, iSign=1, iReady=1 -> two cycles later oMant=0x8000, oExp=9, oSign=1, oZero=0, oDenorm=0.
REQ-035 iMant=0x0001, iExp=3 -> oMant=0x0008, oExp=0, oDenorm=1; iMant=0x0000, iExp=77 -> oMant=0, oExp=0, oZero=1.
REQ-036 iMant=0x8001, iExp=0 -> oMant=0x8001, oExp=0, oDenorm=0, i.e. already normalized, LZ=0 boundary.
REQ-037 Back-to-back 8 operands with iReady=0 for 4 cycles mid-stream: oReady drops after 2 accepted while stalled, oValid held, outputs stable, all 8 results in order, none lost.
REQ-038 Assert iRst_n=0 with both stages full -> oValid=0 same cycle; after release, the first operand 0x0100/exp 10 yields oMant=0x8000, oExp=3 only.
REQ-039 Random sweep of 10k operands with random iValid/iReady against a reference model: zero mismatches, and oMant[MW-1]=1 whenever oZero=0 and oDenorm=0.

Source files
------------

// File: rtl/fp_normalizer.sv
// Two-stage floating-point mantissa normalizer: S1 captures the operand and its leading-zero count,
// S2 holds the shifted result; valid/ready on both sides with full-rate flow under simultaneous accept.
module fp_normalizer #(
  parameter int MW = 16,
  parameter int EW = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  output logic          oReady,
  input  logic          iSign,
  input  logic [EW-1:0] iExp,
  input  logic [MW-1:0] iMant,
  output logic          oValid,
  input  logic          iReady,
  output logic          oSign,
  output logic [EW-1:0] oExp,
  output logic [MW-1:0] oMant,
  output logic          oZero,
  output logic          oDenorm
);

  localparam int LZW = $clog2(MW);
  localparam int NSL = MW / 8;
  localparam int CW  = ((LZW > EW) ? LZW : EW) + 1;

  function automatic logic [2:0] pe8(input logic [7:0] b);
    logic [2:0] r;
    casez (b)
      8'b1???????: r = 3'd0;
      8'b01??????: r = 3'd1;
      8'b001?????: r = 3'd2;
      8'b0001????: r = 3'd3;
      8'b00001???: r = 3'd4;
      8'b000001??: r = 3'd5;
      8'b0000001?: r = 3'd6;
      default:     r = 3'd7;
    endcase
    return r;
  endfunction

  logic [NSL-1:0] sl_any;
  logic [2:0]     sl_lz [NSL];

  for (genvar g = 0; g < NSL; g++) begin : g_slice
    assign sl_any[g] = |iMant[g*8 +: 8];
    assign sl_lz[g]  = pe8(iMant[g*8 +: 8]);
  end

  // Highest non-empty slice wins; its offset is a multiple of 8, so OR-ing in the slice count is exact.
  logic [LZW-1:0] lz_c;
  logic           found;
  always_comb begin
    lz_c  = '0;
    found = 1'b0;
    for (int s = NSL - 1; s >= 0; s--) begin
      if (!found && sl_any[s]) begin
        lz_c  = LZW'((NSL - 1 - s) * 8) | LZW'(sl_lz[s]);
        found = 1'b1;
      end
    end
  end

  logic           s1_vld_q, s1_vld_d;
  logic           s1_sign_q, s1_sign_d;
  logic [EW-1:0]  s1_exp_q, s1_exp_d;
  logic [MW-1:0]  s1_mant_q, s1_mant_d;
  logic [LZW-1:0] s1_lz_q, s1_lz_d;
  logic           s1_zero_q, s1_zero_d;

  logic           s2_vld_q, s2_vld_d;
  logic           s2_sign_q, s2_sign_d;
  logic [EW-1:0]  s2_exp_q, s2_exp_d;
  logic [MW-1:0]  s2_mant_q, s2_mant_d;
  logic           s2_zero_q, s2_zero_d;
  logic           s2_dnrm_q, s2_dnrm_d;

  logic s2_ld, s1_adv, s1_ld, in_acc;

  assign s2_ld  = !s2_vld_q || iReady;
  assign s1_adv = s1_vld_q && s2_ld;
  assign s1_ld  = !s1_vld_q || s1_adv;
  assign oReady = !s1_vld_q || !s2_vld_q || iReady;
  assign in_acc = iValid && oReady;

  // Shift is clamped to the exponent when the exponent floor is hit.
  logic           fits;
  logic [LZW-1:0] sh;
  logic [MW-1:0]  mant_sh;
  logic [EW-1:0]  exp_n;

  always_comb begin
    fits    = CW'(s1_lz_q) <= CW'(s1_exp_q);
    sh      = fits ? s1_lz_q : LZW'(s1_exp_q);
    mant_sh = s1_mant_q << sh;
    exp_n   = (fits && !s1_zero_q) ? (s1_exp_q - EW'(s1_lz_q)) : '0;
  end

  always_comb begin
    s1_vld_d  = s1_ld ? in_acc : s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_mant_d = s1_mant_q;
    s1_lz_d   = s1_lz_q;
    s1_zero_d = s1_zero_q;
    if (in_acc) begin
      s1_sign_d = iSign;
      s1_exp_d  = iExp;
      s1_mant_d = iMant;
      s1_lz_d   = lz_c;
      s1_zero_d = !found;
    end

    s2_vld_d  = s2_ld ? s1_vld_q : s2_vld_q;
    s2_sign_d = s2_sign_q;
    s2_exp_d  = s2_exp_q;
    s2_mant_d = s2_mant_q;
    s2_zero_d = s2_zero_q;
    s2_dnrm_d = s2_dnrm_q;
    if (s1_adv) begin
      s2_sign_d = s1_sign_q;
      s2_exp_d  = exp_n;
      s2_mant_d = mant_sh;
      s2_zero_d = s1_zero_q;
      s2_dnrm_d = !s1_zero_q && !fits;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_mant_q <= '0;
      s1_lz_q   <= '0;
      s1_zero_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_mant_q <= '0;
      s2_zero_q <= 1'b0;
      s2_dnrm_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_mant_q <= s1_mant_d;
      s1_lz_q   <= s1_lz_d;
      s1_zero_q <= s1_zero_d;
      s2_vld_q  <= s2_vld_d;
      s2_sign_q <= s2_sign_d;
      s2_exp_q  <= s2_exp_d;
      s2_mant_q <= s2_mant_d;
      s2_zero_q <= s2_zero_d;
      s2_dnrm_q <= s2_dnrm_d;
    end
  end

  assign oValid  = s2_vld_q;
  assign oSign   = s2_sign_q;
  assign oExp    = s2_exp_q;
  assign oMant   = s2_mant_q;
  assign oZero   = s2_zero_q;
  assign oDenorm = s2_dnrm_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: queue-based reference model checked every cycle, plus directed literals.
module tb_fp_normalizer;

  logic        iClk = 1'b0;
  logic        iRst_n, iValid, oReady, iSign, oValid, iReady;
  logic        oSign, oZero, oDenorm;
  logic [7:0]  iExp, oExp;
  logic [15:0] iMant, oMant;

  fp_normalizer #(.MW(16), .EW(8)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady),
    .iSign(iSign), .iExp(iExp), .iMant(iMant), .oValid(oValid), .iReady(iReady),
    .oSign(oSign), .oExp(oExp), .oMant(oMant), .oZero(oZero), .oDenorm(oDenorm)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] mant;
    logic        zero;
    logic        denorm;
  } res_t;

  typedef struct {
    res_t r;
    int   t;
  } item_t;

  item_t q[$];
  res_t  outs[$];
  int    checks = 0, errors = 0, cyc = 0;
  logic  last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Normalize by counting leading zeros directly, then clamp at the exponent floor.
  function automatic res_t ref_norm(input logic s, input logic [7:0] e, input logic [15:0] m);
    res_t r;
    int   lz;
    r = '0;
    r.sign = s;
    if (m == 16'h0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    while (m[15-lz] == 1'b0) lz++;
    if (lz <= int'(e)) begin
      r.mant = m << lz;
      r.exp  = 8'(int'(e) - lz);
    end else begin
      r.mant   = m << e;
      r.denorm = 1'b1;
    end
    return r;
  endfunction

  task automatic cycle(input logic rst_n, input logic v, input logic s,
                       input logic [7:0] e, input logic [15:0] m, input logic r);
    logic exp_vld;
    item_t it;
    @(negedge iClk);
    iRst_n = rst_n; iValid = v; iSign = s; iExp = e; iMant = m; iReady = r;
    #1;
    cyc++;
    if (!iRst_n) q.delete();
    exp_vld = (q.size() > 0) && (q[0].t <= cyc - 2);
    chk("oValid", 32'(oValid), 32'(exp_vld));
    chk("oReady", 32'(oReady), 32'((q.size() < 2) || iReady));
    if (exp_vld && oValid) begin
      chk("result", 32'({oSign, oExp, oMant, oZero, oDenorm}), 32'(q[0].r));
      if (!oZero && !oDenorm) chk("msb_set", 32'(oMant[15]), 32'd1);
      if (iReady) begin
        outs.push_back({oSign, oExp, oMant, oZero, oDenorm});
        void'(q.pop_front());
      end
    end
    last_acc = iRst_n && iValid && oReady;
    if (last_acc) begin
      it.r = ref_norm(s, e, m);
      it.t = cyc;
      q.push_back(it);
    end
  endtask

  task automatic idle(input logic r);
    cycle(1'b1, 1'b0, 1'b0, 8'h0, 16'h0, r);
  endtask

  // Single operand with iReady=1: result must be on the outputs exactly two cycles later.
  task automatic directed(input string name, input logic s, input logic [7:0] e,
                          input logic [15:0] m, input res_t expv);
    cycle(1'b1, 1'b1, s, e, m, 1'b1);
    idle(1'b1);
    chk({name, "_early"}, 32'(oValid), 32'd0);
    idle(1'b1);
    chk(name, 32'({oValid, oSign, oExp, oMant, oZero, oDenorm}), 32'({1'b1, expv}));
  endtask

  task automatic async_reset();
    #2 iRst_n = 1'b0;
    #1;
    chk("rst_oValid", 32'(oValid), 32'd0);
    chk("rst_oReady", 32'(oReady), 32'd1);
    chk("rst_outs", 32'({oSign, oExp, oMant, oZero, oDenorm}), 32'd0);
    q.delete();
  endtask

  initial begin
    int sent, guard, got;
    logic saw_block;
    logic [7:0]  e;
    logic [15:0] m;
    logic [7:0]  se [8];
    logic [15:0] sm [8];

    iRst_n = 1'b0; iValid = 1'b0; iSign = 1'b0; iExp = '0; iMant = '0; iReady = 1'b0;

    // Model pins.
    chk("ref_034",  32'(ref_norm(1'b1, 8'd20, 16'h0010)), 32'({1'b1, 8'd9, 16'h8000, 1'b0, 1'b0}));
    chk("ref_035a", 32'(ref_norm(1'b0, 8'd3,  16'h0001)), 32'({1'b0, 8'd0, 16'h0008, 1'b0, 1'b1}));
    chk("ref_035b", 32'(ref_norm(1'b0, 8'd77, 16'h0000)), 32'({1'b0, 8'd0, 16'h0000, 1'b1, 1'b0}));
    chk("ref_036",  32'(ref_norm(1'b0, 8'd0,  16'h8001)), 32'({1'b0, 8'd0, 16'h8001, 1'b0, 1'b0}));

    cycle(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
    chk("reset_outs", 32'({oValid, oSign, oExp, oMant, oZero, oDenorm}), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b1);
    idle(1'b1);

    directed("dir_034",  1'b1, 8'd20, 16'h0010, {1'b1, 8'd9, 16'h8000, 1'b0, 1'b0});
    directed("dir_035a", 1'b0, 8'd3,  16'h0001, {1'b0, 8'd0, 16'h0008, 1'b0, 1'b1});
    directed("dir_035b", 1'b1, 8'd77, 16'h0000, {1'b1, 8'd0, 16'h0000, 1'b1, 1'b0});
    directed("dir_036",  1'b0, 8'd0,  16'h8001, {1'b0, 8'd0, 16'h8001, 1'b0, 1'b0});
    directed("dir_lz7",  1'b0, 8'd7,  16'h0100, {1'b0, 8'd0, 16'h8000, 1'b0, 1'b0});

    // Eight back-to-back operands with a four-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      se[i] = 8'(10 + i);
      sm[i] = 16'h0001 << i;
    end
    outs.delete();
    sent = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sent < 8) begin
        cycle(1'b1, 1'b1, sent[0], se[sent], sm[sent], !(c >= 3 && c < 7));
        if (!oReady) saw_block = 1'b1;
        if (last_acc) sent++;
      end else begin
        idle(1'b1);
      end
    end
    chk("stall_block", 32'(saw_block), 32'd1);
    chk("stall_count", 32'(outs.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < outs.size())
        chk("stall_order", 32'(outs[i]), 32'(ref_norm(i[0], se[i], sm[i])));

    // Reset with both stages full discards everything in flight.
    for (int c = 0; c < 6 && oReady; c++)
      cycle(1'b1, 1'b1, 1'b1, 8'd40, 16'h00F0, 1'b0);
    chk("full_before_rst", 32'({oValid, oReady}), 32'b10);
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, 1'b1);
    idle(1'b1);
    outs.delete();
    directed("post_rst", 1'b0, 8'd10, 16'h0100, {1'b0, 8'd3, 16'h8000, 1'b0, 1'b0});
    for (int c = 0; c < 5; c++) idle(1'b1);
    chk("post_rst_count", 32'(outs.size()), 32'd1);

    // Random sweep.
    sent = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      m = 16'($urandom) >> $urandom_range(0, 16);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 16)) : 8'($urandom);
      cycle(1'b1, $urandom_range(0, 99) < 70, 1'($urandom), e, m, $urandom_range(0, 99) < 70);
      if (last_acc) sent++;
      guard++;
    end
    chk("sweep_sent", 32'(sent), 32'd10000);
    got = 0;
    while (q.size() > 0 && got < 20) begin
      idle(1'b1);
      got++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
